// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared encodings for the multi-cycle MIPS-subset controller: FSM states,
//   datapath mux select codes, opcode/funct maps and the ALUOp codes driven
//   to the shared alu. Everything that names a code lives here so the
//   controller, its alu decoder and any bench agree on one definition.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    // ALUOp codes (the only definition of these values)
    localparam logic [4:0] ALUOp_NOP  = 5'd0;
    localparam logic [4:0] ALUOp_ADD  = 5'd1;
    localparam logic [4:0] ALUOp_ADDU = 5'd2;
    localparam logic [4:0] ALUOp_SUB  = 5'd3;
    localparam logic [4:0] ALUOp_SUBU = 5'd4;
    localparam logic [4:0] ALUOp_AND  = 5'd5;
    localparam logic [4:0] ALUOp_OR   = 5'd6;
    localparam logic [4:0] ALUOp_SLT  = 5'd7;
    localparam logic [4:0] ALUOp_SLL  = 5'd8;
    localparam logic [4:0] ALUOp_SRL  = 5'd9;
    localparam logic [4:0] ALUOp_SRA  = 5'd10;
    localparam logic [4:0] ALUOp_LUI  = 5'd11;
    localparam logic [4:0] ALUOp_EQL  = 5'd12;
    localparam logic [4:0] ALUOp_BNE  = 5'd13;

    // FSM states
    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALUWB,
        ST_BRANCH,
        ST_JUMP
    } state_e;

    // Next-PC select
    localparam logic [1:0] NPC_ALU    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    // Register-file write data select
    localparam logic [1:0] WDSEL_ALUOUT = 2'd0;
    localparam logic [1:0] WDSEL_MDR    = 2'd1;
    localparam logic [1:0] WDSEL_PC     = 2'd2;

    // Destination register select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_31 = 2'd2;

    // alu operand A select
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_A     = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    // alu operand B select
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

    // Opcodes
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    // ALUOp for an R-type computational funct; NOP marks anything that is
    // not an alu R-type instruction (including jr, which never uses the alu).
    function automatic logic [4:0] funct_to_aluop(input logic [5:0] funct);
        logic [4:0] res;
        case (funct)
            FUNCT_ADD:  res = ALUOp_ADD;
            FUNCT_ADDU: res = ALUOp_ADDU;
            FUNCT_SUB:  res = ALUOp_SUB;
            FUNCT_SUBU: res = ALUOp_SUBU;
            FUNCT_AND:  res = ALUOp_AND;
            FUNCT_OR:   res = ALUOp_OR;
            FUNCT_SLT:  res = ALUOp_SLT;
            FUNCT_SLL:  res = ALUOp_SLL;
            FUNCT_SRL:  res = ALUOp_SRL;
            FUNCT_SRA:  res = ALUOp_SRA;
            default:    res = ALUOp_NOP;
        endcase
        return res;
    endfunction

    // Shifts take their A operand from the shamt field instead of rs.
    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FUNCT_SLL) || (funct == FUNCT_SRL) || (funct == FUNCT_SRA);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ---------------------------------------------------------------------------
// mc_alu_dec
//   Combinational alu-side decode for the multi-cycle controller: from the
//   current FSM state and the instruction's op/funct, picks the alu
//   operation, both operand selects and the immediate extension mode.
// Ports
//   state_i    in  FSM state
//   op_i       in  IR[31:26]
//   funct_i    in  IR[5:0]
//   alu_op_o   out ALUOp code
//   srca_o     out alu operand A select
//   srcb_o     out alu operand B select
//   ext_op_o   out 1 = sign-extend immediate, 0 = zero-extend
// ---------------------------------------------------------------------------
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [4:0] alu_op_o,
    output logic [1:0] srca_o,
    output logic [1:0] srcb_o,
    output logic       ext_op_o
);

    always_comb begin
        alu_op_o = ALUOp_ADDU;
        srca_o   = SRCA_PC;
        srcb_o   = SRCB_B;
        ext_op_o = 1'b0;
        case (state_i)
            ST_FETCH: begin
                // PC + 4
                srcb_o = SRCB_FOUR;
            end
            ST_DECODE: begin
                // Speculative branch target PC + (simm << 2) into ALUOut
                srcb_o   = SRCB_IMM_SL2;
                ext_op_o = 1'b1;
            end
            ST_MEMADR: begin
                srca_o   = SRCA_A;
                srcb_o   = SRCB_IMM;
                ext_op_o = 1'b1;
            end
            ST_EXEC_R: begin
                srca_o   = is_shift(funct_i) ? SRCA_SHAMT : SRCA_A;
                srcb_o   = SRCB_B;
                alu_op_o = funct_to_aluop(funct_i);
            end
            ST_EXEC_I: begin
                srca_o = SRCA_A;
                srcb_o = SRCB_IMM;
                case (op_i)
                    OP_ADDI: begin
                        alu_op_o = ALUOp_ADD;
                        ext_op_o = 1'b1;
                    end
                    OP_ORI:  alu_op_o = ALUOp_OR;
                    OP_LUI:  alu_op_o = ALUOp_LUI;
                    default: alu_op_o = ALUOp_ADDU;
                endcase
            end
            ST_BRANCH: begin
                srca_o   = SRCA_A;
                srcb_o   = SRCB_B;
                alu_op_o = (op_i == OP_BNE) ? ALUOp_BNE : ALUOp_EQL;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl
//   Multi-cycle control FSM for a MIPS-subset CPU sharing one alu across
//   FETCH -> DECODE -> EXEC -> (MEM) -> WB. Owns the state register, the
//   next-state logic and every datapath strobe; alu-side selects come from
//   mc_alu_dec.
// Ports
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-high reset
//   op        in  IR[31:26]        funct  in  IR[5:0]
//   zero      in  alu zero flag (branch resolution)
//   PCWrite / IRWrite / MemWrite / RegWrite  out  write strobes
//   RegDst, WDSel, ALUSrcA, ALUSrcB, NPCOp   out  datapath mux selects
//   EXTOp     out immediate extension mode
//   ALUOp     out alu operation
//   illegal   out one-cycle pulse in DECODE for an unsupported instruction
// ---------------------------------------------------------------------------
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       EXTOp,
    output logic [1:0] NPCOp,
    output logic [4:0] ALUOp,
    output logic       illegal
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    mc_alu_dec u_alu_dec (
        .state_i  (state_q),
        .op_i     (op),
        .funct_i  (funct),
        .alu_op_o (ALUOp),
        .srca_o   (ALUSrcA),
        .srcb_o   (ALUSrcB),
        .ext_op_o (EXTOp)
    );

    always_comb begin
        // Every state lasts exactly one cycle; falling back to FETCH is the
        // safe default for anything not listed.
        state_d  = ST_FETCH;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = REGDST_RT;
        WDSel    = WDSEL_ALUOUT;
        NPCOp    = NPC_ALU;
        illegal  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                PCWrite = 1'b1;
                IRWrite = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (op)
                    OP_R: begin
                        if (funct == FUNCT_JR) begin
                            state_d = ST_JUMP;
                        end else if (funct_to_aluop(funct) != ALUOp_NOP) begin
                            state_d = ST_EXEC_R;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW:            state_d = ST_MEMADR;
                    OP_ADDI, OP_ORI, OP_LUI: state_d = ST_EXEC_I;
                    OP_BEQ, OP_BNE:          state_d = ST_BRANCH;
                    OP_J, OP_JAL:            state_d = ST_JUMP;
                    default:                 illegal = 1'b1;
                endcase
            end
            ST_MEMADR: begin
                state_d = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                RegDst   = REGDST_RT;
                WDSel    = WDSEL_MDR;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
            end
            ST_EXEC_R, ST_EXEC_I: begin
                state_d = ST_ALUWB;
            end
            ST_ALUWB: begin
                RegWrite = 1'b1;
                WDSel    = WDSEL_ALUOUT;
                RegDst   = (op == OP_R) ? REGDST_RD : REGDST_RT;
            end
            ST_BRANCH: begin
                // Only input-dependent strobe: taken iff the alu compare hit.
                NPCOp   = NPC_BRANCH;
                PCWrite = zero;
            end
            ST_JUMP: begin
                PCWrite = 1'b1;
                NPCOp   = (op == OP_R) ? NPC_JR : NPC_JUMP;
                if (op == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = REGDST_31;
                    WDSel    = WDSEL_PC;
                end
            end
            default: ;
        endcase

        // While reset is held the state already reads FETCH (so muxes show
        // FETCH values); only the strobes and the illegal pulse are masked.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule
